// File: rtl/rcl_pkg.sv
// Shared types and constants for the RCL coefficient initiator and its reference model.
package rcl_pkg;

  localparam int unsigned COEF_W = 5;
  localparam int unsigned S_W    = 11;
  localparam int unsigned R_W    = 16;
  localparam int unsigned D_W    = 24;

  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,
    REL_TANGENT = 2'd1,
    REL_SECANT  = 2'd2,
    REL_INVALID = 2'd3
  } rel_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StSend0 = 3'd1,
    StSend1 = 3'd2,
    StSend2 = 3'd3,
    StWait  = 3'd4,
    StResp  = 3'd5
  } tx_state_e;

  typedef struct packed {
    logic signed [COEF_W-1:0] a;
    logic signed [COEF_W-1:0] b;
    logic signed [COEF_W-1:0] c;
    logic signed [COEF_W-1:0] m;
    logic signed [COEF_W-1:0] n;
    logic        [COEF_W-1:0] k;
  } coef_job_t;

endpackage

// File: rtl/rcl_coef_tx_rel_model.sv
// Combinational line/circle relation calculator: compares (a^2+b^2)*k against (a*m+b*n+c)^2.
module rcl_rel_model
  import rcl_pkg::*;
(
  input  logic signed [COEF_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  input  logic signed [COEF_W-1:0] c_i,
  input  logic signed [COEF_W-1:0] m_i,
  input  logic signed [COEF_W-1:0] n_i,
  input  logic        [COEF_W-1:0] k_i,
  output logic        [1:0]        rel_o
);

  logic signed [S_W-1:0] a_x, b_x, c_x, m_x, n_x;
  logic signed [S_W-1:0] sq_sum, s;
  logic signed [D_W-1:0] s_x;
  logic        [R_W-1:0] r;
  logic        [D_W-1:0] d;

  always_comb begin
    a_x    = S_W'(a_i);
    b_x    = S_W'(b_i);
    c_x    = S_W'(c_i);
    m_x    = S_W'(m_i);
    n_x    = S_W'(n_i);
    sq_sum = a_x * a_x + b_x * b_x;
    // sq_sum is never negative, so the unsigned view is exact
    r      = R_W'($unsigned(sq_sum)) * R_W'(k_i);
    s      = a_x * m_x + b_x * n_x + c_x;
    s_x    = D_W'(s);
    d      = $unsigned(s_x * s_x);
    if (D_W'(r) < d) begin
      rel_o = REL_NONE;
    end else if (D_W'(r) == d) begin
      rel_o = REL_TANGENT;
    end else begin
      rel_o = REL_SECANT;
    end
  end

endmodule

// File: rtl/rcl_coef_tx.sv
// RCL coefficient initiator: serialises one job over 3 beats and returns the relation upstream.
// Define RCL_TX_CHECK_EN to compare the responder's answer against a local model.
module rcl_coef_tx
  import rcl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [COEF_W-1:0] req_a_i,
  input  logic [COEF_W-1:0] req_b_i,
  input  logic [COEF_W-1:0] req_c_i,
  input  logic [COEF_W-1:0] req_m_i,
  input  logic [COEF_W-1:0] req_n_i,
  input  logic [COEF_W-1:0] req_k_i,
  output logic              tx_valid_o,
  output logic [COEF_W-1:0] tx_coef_l_o,
  output logic [COEF_W-1:0] tx_coef_q_o,
  input  logic              rx_valid_i,
  input  logic [1:0]        rx_out_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [1:0]        rsp_rel_o,
  output logic              rsp_timeout_o,
  output logic              rsp_mismatch_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  tx_state_e  state_q;
  coef_job_t  job_q;
  logic [7:0] wait_cnt_q;
  logic [1:0] rsp_rel_q;
  logic       rsp_timeout_q;
  logic       rsp_mismatch_q;
  logic       mismatch_d;

`ifdef RCL_TX_CHECK_EN
  logic [1:0] exp_rel;

  rcl_rel_model u_rel_model (
    .a_i   (job_q.a),
    .b_i   (job_q.b),
    .c_i   (job_q.c),
    .m_i   (job_q.m),
    .n_i   (job_q.n),
    .k_i   (job_q.k),
    .rel_o (exp_rel)
  );

  assign mismatch_d = (rx_out_i != exp_rel);
`else
  assign mismatch_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      job_q          <= '0;
      wait_cnt_q     <= '0;
      rsp_rel_q      <= REL_NONE;
      rsp_timeout_q  <= 1'b0;
      rsp_mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            job_q   <= '{a: req_a_i, b: req_b_i, c: req_c_i,
                         m: req_m_i, n: req_n_i, k: req_k_i};
            state_q <= StSend0;
          end
        end
        StSend0: state_q <= StSend1;
        StSend1: state_q <= StSend2;
        StSend2: begin
          wait_cnt_q <= '0;
          state_q    <= StWait;
        end
        StWait: begin
          // A response arriving on the last allowed cycle still beats the timeout
          if (rx_valid_i) begin
            rsp_rel_q      <= rx_out_i;
            rsp_timeout_q  <= 1'b0;
            rsp_mismatch_q <= mismatch_d;
            state_q        <= StResp;
          end else if (wait_cnt_q == TimeoutLast) begin
            rsp_rel_q      <= REL_INVALID;
            rsp_timeout_q  <= 1'b1;
            rsp_mismatch_q <= 1'b0;
            state_q        <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_rel_q      <= REL_NONE;
            rsp_timeout_q  <= 1'b0;
            rsp_mismatch_q <= 1'b0;
            state_q        <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    tx_valid_o  = 1'b0;
    tx_coef_l_o = '0;
    tx_coef_q_o = '0;
    case (state_q)
      StSend0: begin
        tx_valid_o  = 1'b1;
        tx_coef_l_o = job_q.a;
        tx_coef_q_o = job_q.m;
      end
      StSend1: begin
        tx_valid_o  = 1'b1;
        tx_coef_l_o = job_q.b;
        tx_coef_q_o = job_q.n;
      end
      StSend2: begin
        tx_valid_o  = 1'b1;
        tx_coef_l_o = job_q.c;
        tx_coef_q_o = job_q.k;
      end
      default: ;
    endcase
  end

  assign req_ready_o    = (state_q == StIdle);
  assign rsp_valid_o    = (state_q == StResp);
  assign rsp_rel_o      = rsp_rel_q;
  assign rsp_timeout_o  = rsp_timeout_q;
  assign rsp_mismatch_o = rsp_mismatch_q;

endmodule

// File: doc/rcl_coef_tx.md
Name: rcl_coef_tx

Overview:
- Initiator end of the line/circle relation (RCL) coefficient protocol.
- Accepts one parallel job: line coefficients a, b, c and circle coefficients m, n, k.
- Serialises the job over 3 cycles on in_valid/coef_L/coef_Q to a downstream RCL responder.
- Waits for the responder's out_valid/out, then returns the 2-bit relation (or a timeout flag) upstream with a valid/ready handshake.

Parameters:
- TIMEOUT_CYC, 8: maximum cycles spent in WAIT for rx_valid before a timeout response. Legal range 2..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- req_valid  in  1  job offered
- req_ready  out  1  block can accept a job
- req_a, req_b, req_c  in  5 each  signed line coefficients
- req_m, req_n  in  5 each  signed circle centre
- req_k  in  5  unsigned radius squared
- tx_valid  out  1  drives responder in_valid
- tx_coef_l  out  5  drives responder coef_L
- tx_coef_q  out  5  drives responder coef_Q
- rx_valid  in  1  responder out_valid
- rx_out  in  2  responder out
- rsp_valid  out  1  result available
- rsp_ready  in  1  upstream takes result
- rsp_rel  out  2  relation: 0 = none, 1 = tangent, 2 = secant, 3 = invalid/timeout
- rsp_timeout  out  1  qualifies rsp_rel = 3
- rsp_mismatch  out  1  checker flag; see Optional Feature

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: all outputs 0 except req_ready = 1 (state IDLE). All outputs are registered or decoded from state; there is no combinational input-to-output path.
- FSM states: IDLE, SEND0, SEND1, SEND2, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch all six operands and go to SEND0.
- SEND0: tx_valid = 1, tx_coef_l = a, tx_coef_q = m.
- SEND1: tx_valid = 1, tx_coef_l = b, tx_coef_q = n.
- SEND2: tx_valid = 1, tx_coef_l = c, tx_coef_q = k. Then go to WAIT.
- Bus timing:
  - Exactly 3 consecutive tx_valid cycles per job.
  - tx_valid rises 1 cycle after the accepting edge.
  - tx_coef_* = 0 whenever tx_valid = 0.
- WAIT:
  - tx_valid = 0. A wait counter clears on entry and increments each cycle.
  - If rx_valid = 1: capture rx_out into rsp_rel, rsp_timeout = 0, go to RESP.
  - Else, if the counter reaches TIMEOUT_CYC - 1: rsp_rel = 3, rsp_timeout = 1, go to RESP.
  - If rx_valid and timeout occur in the same cycle, rx_valid wins.
  - A compliant responder asserts rx_valid 2 cycles after the last tx_valid cycle.
- RESP:
  - rsp_valid = 1; rsp_rel, rsp_timeout and rsp_mismatch are held stable until rsp_ready.
  - rsp_valid && rsp_ready: go to IDLE and clear rsp_* the next cycle.
  - This guarantees at least 2 tx_valid = 0 cycles between jobs, which the responder requires to return to idle.
- rx_valid outside WAIT is ignored.
- req_valid outside IDLE is ignored (req_ready = 0).
- Reset mid-job: immediate return to IDLE, tx_valid drops, and the job is lost.
- Back-to-back throughput: one job per 3 + latency + 1 + rsp wait cycles minimum.

Optional Feature:
- Macro RCL_TX_CHECK_EN.
- When defined, a local model computes the expected relation from the latched operands:
  - r = (a*a + b*b) * k, 11-bit signed sum times unsigned k, 16-bit result.
  - s = a*m + b*n + c, 11-bit signed.
  - d = s*s, 24-bit unsigned.
  - expected = 0 if r < d, 1 if r == d, 2 if r > d.
- On the RESP entry edge (non-timeout only), rsp_mismatch = (rx_out != expected). On timeout, rsp_mismatch = 0.
- When not defined: rsp_mismatch is tied to 0 and no model logic is synthesised.
- Port list is identical in both builds.

Decomposition:
- Package rcl_pkg:
  - relation codes REL_NONE = 0, REL_TANGENT = 1, REL_SECANT = 2, REL_INVALID = 3.
  - COEF_W = 5.
  - FSM state encoding.
  - widths R_W = 16, D_W = 24.
- Sub-module rcl_rel_model: the combinational expected-relation calculator, instantiated only under RCL_TX_CHECK_EN. The same sub-module is reusable by the responder's testbench.

Test Plan:
- Single job a=1, b=0, c=0, m=0, n=0, k=1:
  - tx bus shows (L,Q) = (1,0), (0,0), (0,1) on 3 consecutive cycles.
  - Compliant responder returns 2 → rsp_rel = 2, rsp_timeout = 0, rsp_mismatch = 0.
- Tangent: a=1, b=0, c=-2 (5'b11110), m=0, n=0, k=4 → responder returns 1 → rsp_rel = 1. Same job with k=1 → rsp_rel = 0.
- Timeout with TIMEOUT_CYC = 8 and rx_valid never asserted:
  - rsp_valid rises 8 cycles after the last tx_valid.
  - rsp_rel = 3, rsp_timeout = 1.
  - rx_valid pulsed in that 8th WAIT cycle instead → normal capture, no timeout.
- Backpressure:
  - Hold rsp_ready = 0 for 10 cycles: rsp_* stay stable and req_ready = 0.
  - req_valid held high throughout: second job starts only after the rsp handshake, with ≥2 idle tx cycles between jobs.
- Reset mid-job: assert rst_n = 0 during SEND1 → tx_valid = 0 and req_ready = 1 after release, and a late rx_valid is ignored.
- With RCL_TX_CHECK_EN: faulty responder returns 0 for the secant job → rsp_mismatch = 1. Without the macro → rsp_mismatch = 0.
